tick_generator: RTL and testbench
=================================

# tick_generator

Parametrised successor to the game's rate divider: converts `clk` into single-cycle `tick` strobes at one of four programmable periods. Adds start/stop/restart control, pause, one-shot mode and a wrapping tick counter. It drives piece-drop animation, blink and turn-timeout timing in the Connect-4 datapath. It presents the same 2-bit `speed` select as the earlier divider, so existing control FSMs can retarget to it directly.

## Interface
- `CNT_W`, 28: width of the internal down-counter; every preset must fit in `CNT_W` bits.
- `P1`, 49999999: reload value for `speed`=01 (1 s at 50 MHz).
- `P2`, 2777777: reload value for `speed`=10.
- `P3`, 6249999: reload value for `speed`=11.
- `TC_W`, 8: width of `tick_count`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `speed`  in  2  period select: 00 gives P=0 (tick every cycle), 01 gives P1, 10 gives P2, 11 gives P3.
- `start`  in  1  synchronous; in IDLE, starts counting.
- `stop`  in  1  synchronous; returns to IDLE from any state.
- `restart`  in  1  synchronous; reloads the counter, clears `tick_count` and enters RUN from any state.
- `run_en`  in  1  pause control; while low, the counter freezes in RUN.
- `oneshot`  in  1  mode, sampled on start/restart: 1 = single tick, then DONE.
- `tick`  out  1  one-cycle strobe.
- `tick_count`  out  TC_W  ticks since last restart/start; wraps modulo 2^TC_W.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.

## Operation
- State: FSM {IDLE, RUN, DONE}, down-counter `rate[CNT_W-1:0]`, latched mode bit `os`.
- P(speed) is the preset selected by the current `speed` value at the moment of any load.
- Priority each cycle: `restart` > `stop` > `start` > normal counting.
- `restart` (any state): load `rate`=P(speed), latch `os`=`oneshot`, clear `tick_count` to 0, go to RUN; no tick that cycle.
- `stop` (any state, no restart): go to IDLE; `rate` and `tick_count` hold their values.
- IDLE with `start`: same actions as `restart`. `start` is ignored in RUN and DONE.
- `tick` is combinational: tick = (state==RUN) & `run_en` & (`rate`==0) & ~`restart` & ~`stop`.
- RUN, `run_en`=1, `rate`!=0: decrement `rate` by 1.
- RUN, tick cycle:
  - `tick_count` increments by 1, wrapping.
  - If `os`=0, reload `rate`=P(speed) and stay in RUN.
  - If `os`=1, go to DONE.
- RUN, `run_en`=0: `rate`, state and `tick_count` all hold; `tick`=0.
- A `speed` change during RUN takes effect only at the next reload; the interval in progress is never shortened or lengthened.
- DONE: holds until `restart` or `stop`; `tick`=0.

## Timing
- Reset (async, immediate): state=IDLE, `rate`=0, `os`=0, `tick_count`=0.
  - All outputs are 0 while `clear` is high and after it releases.
- Start latency: with `start` sampled at edge 0, the first tick is high during cycle P+1 after that edge.
- Periodic mode: ticks repeat every P+1 cycles. P=0 gives `tick` continuously high from the first cycle after the start edge.
- Pause: each cycle with `run_en` low delays all subsequent ticks by exactly one cycle.
- `restart` coincident with a would-be tick: no tick, no increment; the counter reloads.
- `stop` coincident with a would-be tick: no tick, no increment.
- `clear` mid-count: immediate return to the reset state. The first tick after reset requires a new `start`.
- `tick_count` wrap: 2^TC_W−1 → 0 on the next tick. No overflow flag.

## Test plan
Test parameters: CNT_W=4, P1=3, P2=1, P3=5, TC_W=3.
- Reset and idle: assert `clear` mid-run with `rate`≠0 → outputs 0 immediately. After release, hold `start` low 10 cycles → `tick` stays 0 and `busy` stays 0.
- Periodic, `speed`=01, pulse `start` → ticks at cycles 4, 8, 12.
  - After 8 ticks, `tick_count` wraps 7→0.
- `speed`=00 → `tick` high every cycle from cycle 1.
  - Switching to 11 mid-run: the next tick comes 6 cycles after the last P=0 tick.
- One-shot, `speed`=11, `oneshot`=1, `start` → a single tick at cycle 6, then `done`=1 and `busy`=0.
  - A later `start` is ignored; `restart` re-arms the block.
- Pause: `speed`=01, drop `run_en` for 3 cycles at cycle 2 → the first tick moves from cycle 4 to cycle 7.
- Collisions:
  - `restart` on a tick cycle → no tick, `tick_count`=0, next tick at P+1.
  - `stop` and `restart` together → RUN.
  - `stop` on a tick cycle → IDLE, no increment.

Source files
------------

// File: rtl/tick_generator.sv
// -----------------------------------------------------------------------------
// tick_generator
//
// Turns the system clock into single-cycle `tick` strobes at one of four
// programmable periods. Successor to the fixed rate divider used by the game;
// it keeps the same 2-bit `speed` select, so existing control FSMs can drive it
// unchanged. It adds start/stop/restart control, a pause input, a one-shot mode
// and a wrapping tick counter.
//
// Parameters:
//   CNT_W  width of the internal down-counter (every preset must fit in it)
//   P1     reload value for speed = 01
//   P2     reload value for speed = 10
//   P3     reload value for speed = 11   (speed = 00 reloads 0)
//   TC_W   width of tick_count
//
// Ports:
//   clk         in   system clock, all state changes on the rising edge
//   clear       in   asynchronous active-high reset
//   speed       in   period select, sampled whenever the counter is loaded
//   start       in   starts counting from IDLE (ignored in RUN and DONE)
//   stop        in   returns to IDLE from any state
//   restart     in   reload, clear tick_count and enter RUN from any state
//   run_en      in   pause control; low freezes the counter while in RUN
//   oneshot     in   mode latched on start/restart: 1 = one tick then DONE
//   tick        out  one-cycle strobe
//   tick_count  out  ticks since the last start/restart, wraps
//   busy        out  high in RUN
//   done        out  high in DONE
// -----------------------------------------------------------------------------
module tick_generator #(
  parameter int CNT_W = 28,
  parameter int P1    = 49999999,
  parameter int P2    = 2777777,
  parameter int P3    = 6249999,
  parameter int TC_W  = 8
) (
  input  logic            clk,
  input  logic            clear,
  input  logic [1:0]      speed,
  input  logic            start,
  input  logic            stop,
  input  logic            restart,
  input  logic            run_en,
  input  logic            oneshot,
  output logic            tick,
  output logic [TC_W-1:0] tick_count,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PRESET_1 = CNT_W'(P1);
  localparam logic [CNT_W-1:0] PRESET_2 = CNT_W'(P2);
  localparam logic [CNT_W-1:0] PRESET_3 = CNT_W'(P3);

  state_t            state_q;
  logic [CNT_W-1:0]  rate_q;
  logic [CNT_W-1:0]  rate_d;
  logic [TC_W-1:0]   tc_q;
  logic              os_q;

  logic [CNT_W-1:0]  preset;
  logic              rate_zero;
  logic              load;

  // Preset for the speed currently on the input. Only consulted when the
  // counter is loaded, so a speed change mid-interval never alters the
  // interval already in progress.
  always_comb begin
    preset = '0;
    unique case (speed)
      2'b00: preset = '0;
      2'b01: preset = PRESET_1;
      2'b10: preset = PRESET_2;
      2'b11: preset = PRESET_3;
      default: preset = '0;
    endcase
  end

  assign rate_zero = (rate_q == '0);

  // A tick is suppressed by restart/stop in the same cycle: those commands
  // take priority over the count that would otherwise complete.
  assign tick = (state_q == ST_RUN) & run_en & rate_zero & ~restart & ~stop;

  // restart from anywhere, or start from IDLE, performs the same (re)load.
  assign load = restart | (~stop & start & (state_q == ST_IDLE));

  // Next value of the down-counter while running un-paused.
  always_comb begin
    rate_d = rate_q;
    if (rate_zero) begin
      rate_d = preset;
    end else begin
      rate_d = rate_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      rate_q  <= '0;
      tc_q    <= '0;
      os_q    <= 1'b0;
    end else if (load) begin
      state_q <= ST_RUN;
      rate_q  <= preset;
      tc_q    <= '0;
      os_q    <= oneshot;
    end else if (stop) begin
      // Counter and tick count are deliberately left as they were.
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_RUN: begin
          if (run_en) begin
            if (rate_zero) begin
              tc_q <= tc_q + TC_W'(1);
              if (os_q) begin
                state_q <= ST_DONE;
              end else begin
                rate_q <= rate_d;
              end
            end else begin
              rate_q <= rate_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign tick_count = tc_q;
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_tick_generator.sv
// -----------------------------------------------------------------------------
// tb_tick_generator
//
// Directed bench for tick_generator with small presets (CNT_W=4, P1=3, P2=1,
// P3=5, TC_W=3). Inputs change 1 time unit after a rising edge; outputs are
// compared 1 unit later, well away from the next edge. "Cycle k" means the
// k-th clock period after the edge that sampled start/restart.
// -----------------------------------------------------------------------------
module tb_tick_generator;

  logic       clk;
  logic       clear;
  logic [1:0] speed;
  logic       start;
  logic       stop;
  logic       restart;
  logic       run_en;
  logic       oneshot;
  logic       tick;
  logic [2:0] tick_count;
  logic       busy;
  logic       done;

  int checks;
  int errors;

  tick_generator #(
    .CNT_W(4),
    .P1   (3),
    .P2   (1),
    .P3   (5),
    .TC_W (3)
  ) dut (
    .clk       (clk),
    .clear     (clear),
    .speed     (speed),
    .start     (start),
    .stop      (stop),
    .restart   (restart),
    .run_en    (run_en),
    .oneshot   (oneshot),
    .tick      (tick),
    .tick_count(tick_count),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after inputs were changed.
  task automatic settle();
    #1;
  endtask

  // Single-cycle command pulse; returns at the start of cycle 1.
  task automatic pulse_start();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    next_cycle();
    restart = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clear   = 1'b1;
    speed   = 2'b00;
    start   = 1'b0;
    stop    = 1'b0;
    restart = 1'b0;
    run_en  = 1'b1;
    oneshot = 1'b0;

    // ---------------- reset ----------------
    repeat (3) next_cycle();
    settle();
    check_val("reset_outputs", {tick, busy, done, tick_count}, 0);
    clear = 1'b0;
    next_cycle();

    // ---------------- clear mid-run ----------------
    speed = 2'b01;
    pulse_start();
    next_cycle();                          // cycle 2, rate = 2
    settle();
    check_val("midrun_busy", busy, 1);
    clear = 1'b1;
    settle();
    check_val("clear_async", {tick, busy, done, tick_count}, 0);
    next_cycle();
    clear = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      settle();
      check_val($sformatf("idle_%0d", k), {tick, busy}, 0);
    end

    // ---------------- periodic, speed 01 (P=3) ----------------
    speed = 2'b01;
    pulse_start();
    for (int k = 1; k <= 33; k++) begin
      settle();
      check_val($sformatf("per_tick_c%0d", k), tick, (k % 4 == 0) ? 1 : 0);
      if (k == 12) check_val("per_count_c12", tick_count, 2);
      if (k == 29) check_val("per_count_c29", tick_count, 7);
      if (k == 33) check_val("per_wrap_c33", tick_count, 0);
      if (k != 33) next_cycle();
    end
    pulse_stop();
    settle();
    check_val("per_stop_busy", busy, 0);

    // ---------------- speed 00 then switch to 11 ----------------
    speed = 2'b00;
    pulse_start();
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) speed = 2'b11;
      settle();
      check_val($sformatf("p0_tick_c%0d", k), tick, 1);
      next_cycle();
    end
    for (int k = 6; k <= 11; k++) begin
      settle();
      check_val($sformatf("sw_tick_c%0d", k), tick, (k == 11) ? 1 : 0);
      next_cycle();
    end
    check_val("sw_count", tick_count, 6);
    pulse_stop();

    // ---------------- one-shot, speed 11 (P=5) ----------------
    speed   = 2'b11;
    oneshot = 1'b1;
    pulse_start();
    for (int k = 1; k <= 6; k++) begin
      settle();
      check_val($sformatf("os_tick_c%0d", k), tick, (k == 6) ? 1 : 0);
      next_cycle();
    end
    settle();
    check_val("os_done", {done, busy, tick}, 3'b100);
    check_val("os_count", tick_count, 1);
    pulse_start();
    settle();
    check_val("os_start_ignored", {done, busy, tick}, 3'b100);
    pulse_restart();
    settle();
    check_val("os_rearm", {done, busy, tick_count}, 5'b01000);
    for (int k = 1; k <= 6; k++) begin
      settle();
      check_val($sformatf("os2_tick_c%0d", k), tick, (k == 6) ? 1 : 0);
      next_cycle();
    end
    settle();
    check_val("os2_done", {done, busy}, 2'b10);
    oneshot = 1'b0;
    pulse_stop();

    // ---------------- pause, speed 01 ----------------
    speed = 2'b01;
    pulse_start();
    for (int k = 1; k <= 10; k++) begin
      run_en = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
      settle();
      check_val($sformatf("pause_tick_c%0d", k), tick, (k == 7) ? 1 : 0);
      if (k == 3) check_val("pause_busy", busy, 1);
      next_cycle();
    end
    // Next periodic tick is at cycle 11 of this run: collide restart with it.
    restart = 1'b1;
    settle();
    check_val("rst_coll_tick", tick, 0);
    next_cycle();
    restart = 1'b0;
    settle();
    check_val("rst_coll_count", tick_count, 0);
    check_val("rst_coll_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      settle();
      check_val($sformatf("rst_next_c%0d", k), tick, (k == 4) ? 1 : 0);
      next_cycle();
    end

    // stop together with restart: restart wins
    stop    = 1'b1;
    restart = 1'b1;
    next_cycle();
    stop    = 1'b0;
    restart = 1'b0;
    settle();
    check_val("stop_rst_busy", busy, 1);
    check_val("stop_rst_count", tick_count, 0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) stop = 1'b1;
      settle();
      check_val($sformatf("stopcoll_tick_c%0d", k), tick, (k == 4) ? 1 : 0);
      if (k != 8) next_cycle();
    end
    next_cycle();
    stop = 1'b0;
    settle();
    check_val("stop_coll_busy", {busy, done}, 0);
    check_val("stop_coll_count", tick_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
